// File: rtl/stopwatch_core_if.sv
// -----------------------------------------------------------------------------
// stopwatch_core_if
//   Groups every stopwatch_core signal except clk/rst.
//   master : upstream side (debouncers, clock divider) driving pulses and levels,
//            and receiving the display value and status flags.
//   slave  : the stopwatch_core itself.
//
//   Pulses (one cycle) : tick, adj_tick, clear, pause_toggle, lap
//   Levels             : dir (0 up / 1 down), adj (adjust mode), sel, num
//   Outputs            : digits (BCD, digit i at [4i+3:4i]), running, expired,
//                        lap_active, wrap (one-cycle rollover pulse)
// -----------------------------------------------------------------------------
interface stopwatch_core_if #(
  parameter int DIGITS = 4,
  parameter int SEL_W  = 2
) ();
  logic                  tick;
  logic                  adj_tick;
  logic                  clear;
  logic                  pause_toggle;
  logic                  lap;
  logic                  dir;
  logic                  adj;
  logic [SEL_W-1:0]      sel;
  logic [3:0]            num;
  logic [4*DIGITS-1:0]   digits;
  logic                  running;
  logic                  expired;
  logic                  lap_active;
  logic                  wrap;

  modport master (
    output tick, adj_tick, clear, pause_toggle, lap, dir, adj, sel, num,
    input  digits, running, expired, lap_active, wrap
  );

  modport slave (
    input  tick, adj_tick, clear, pause_toggle, lap, dir, adj, sel, num,
    output digits, running, expired, lap_active, wrap
  );
endinterface

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//   Chain of DIGITS BCD digits, each radix 10 or 6 (RADIX6_MASK), counting up
//   or down in RUN, with per-digit clamped loading in ADJUST, a lap/split hold
//   and expiry (count-down reaching zero) / wrap (count-up rollover) flags.
//
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-high reset
//     bus  : stopwatch_core_if.slave (pulses, levels, display and status)
//
//   Within one cycle the inputs rank clear > adj > pause_toggle > lap >
//   tick/adj_tick: a higher-ranked pulse that is present suppresses the
//   lower-ranked ones for that cycle.
// -----------------------------------------------------------------------------
module stopwatch_core #(
  parameter int              DIGITS      = 4,
  parameter int              SEL_W       = 2,
  parameter logic [DIGITS-1:0] RADIX6_MASK = 4'b1010
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_core_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_RUN     = 2'd1,
    ST_ADJUST  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [4*DIGITS-1:0] r_count;
  logic [4*DIGITS-1:0] r_snap;
  logic                r_lap_active;
  logic                r_wrap;

  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;
  logic [4*DIGITS-1:0] w_load;
  logic [DIGITS:0]     w_carry;
  logic [DIGITS:0]     w_borrow;
  logic                w_all_max;
  logic                w_count_zero;
  logic                w_dec_zero;
  logic                w_lap_en;
  logic                w_count_en;
  logic                w_load_en;

  // ---------------------------------------------------------------------------
  // Per-digit BCD arithmetic. Digit 0 always sees a carry/borrow-in of 1; a
  // digit passes the carry on only when it sits at its maximum (up) or at
  // zero (down), so no intermediate wider than one digit ever exists.
  // ---------------------------------------------------------------------------
  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam logic [3:0] MAX = RADIX6_MASK[gi] ? 4'd5 : 4'd9;
    logic [3:0] w_d;
    logic       w_at_max;
    logic       w_at_zero;

    assign w_d       = r_count[4*gi +: 4];
    assign w_at_max  = (w_d == MAX);
    assign w_at_zero = (w_d == 4'd0);

    assign w_carry[gi+1]  = w_carry[gi]  & w_at_max;
    assign w_borrow[gi+1] = w_borrow[gi] & w_at_zero;

    assign w_inc[4*gi +: 4] = !w_carry[gi]  ? w_d : (w_at_max  ? 4'd0 : w_d + 4'd1);
    assign w_dec[4*gi +: 4] = !w_borrow[gi] ? w_d : (w_at_zero ? MAX  : w_d - 4'd1);

    // A sel value beyond the last digit matches no digit and loads nothing.
    assign w_load[4*gi +: 4] = (bus.sel == SEL_W'(gi))
                             ? ((bus.num > MAX) ? MAX : bus.num)
                             : w_d;
  end

  assign w_all_max    = w_carry[DIGITS];
  assign w_count_zero = (r_count == '0);
  assign w_dec_zero   = (w_dec == '0);

  // Qualified actions after applying the input ranking.
  assign w_lap_en   = bus.lap && !bus.clear && !bus.adj && !bus.pause_toggle &&
                      ((r_state == ST_RUN) || (r_state == ST_PAUSED));
  assign w_count_en = bus.tick && !bus.clear && !bus.adj && !bus.pause_toggle &&
                      !bus.lap && (r_state == ST_RUN);
  assign w_load_en  = bus.adj_tick && !bus.clear && bus.adj && (r_state == ST_ADJUST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_PAUSED;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees every path drives
  // w_state_nxt, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = bus.adj ? ST_ADJUST : ST_PAUSED;
    end else if (bus.adj) begin
      w_state_nxt = ST_ADJUST;
    end else if (r_state == ST_ADJUST) begin
      w_state_nxt = ST_PAUSED;               // adj has fallen
    end else if (bus.pause_toggle) begin
      case (r_state)
        // A count-down from zero would expire immediately; refuse to start.
        ST_PAUSED: if (!(bus.dir && w_count_zero)) w_state_nxt = ST_RUN;
        ST_RUN:    w_state_nxt = ST_PAUSED;
        default:   w_state_nxt = r_state;
      endcase
    end else if (w_count_en && bus.dir && w_dec_zero) begin
      w_state_nxt = ST_EXPIRED;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registers only; display is a plain mux)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.running    = (r_state == ST_RUN);
    bus.expired    = (r_state == ST_EXPIRED);
    bus.lap_active = r_lap_active;
    bus.wrap       = r_wrap;
    bus.digits     = r_lap_active ? r_snap : r_count;
  end

  // ---------------------------------------------------------------------------
  // Count, lap snapshot and wrap pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_snap       <= '0;
      r_lap_active <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.clear) begin
        r_count      <= '0;
        r_lap_active <= 1'b0;
      end else if (bus.adj) begin
        r_lap_active <= 1'b0;
        if (w_load_en) r_count <= w_load;
      end else if (w_lap_en) begin
        // First lap freezes the live count; the second releases the display.
        if (!r_lap_active) r_snap <= r_count;
        r_lap_active <= !r_lap_active;
      end else if (w_count_en) begin
        if (bus.dir) begin
          r_count <= w_dec;
        end else begin
          r_count <= w_inc;
          r_wrap  <= w_all_max;
        end
      end
    end
  end

endmodule
